// File: rtl/tcu_drl_step_sched.sv
// -----------------------------------------------------------------------------
// tcu_drl_step_sched
//   Sequencer in front of the DRL tensor-core dot-product datapath. Takes one
//   dot-product job (format, K-step count, C seed, tag), pulls one operand beat
//   per K step and issues it to the datapath with first/last markers (C only on
//   the first step), waits for the final result with a bounded timer, then
//   returns it on a valid/ready response port.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   req_*                     job request (valid/ready, fmt, steps, c, tag)
//   opd_*                     operand beat stream (valid/ready, A row, B col)
//   dp_*  (out)               registered issue to the datapath
//   dp_res_valid, dp_res      datapath result strobe and value
//   rsp_*                     response (valid/ready, data, tag, err)
//   busy                      FSM not idle
// -----------------------------------------------------------------------------

// Per-lane operand holding register: loads one A/B word pair on issue and
// holds it otherwise so the datapath payload stays stable between pulses.
module tcu_drl_step_sched_lane (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ld,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic [31:0] a_out,
   output logic [31:0] b_out
);
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;

   always_comb begin
      a_d = ld ? a_in : a_q;
      b_d = ld ? b_in : b_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
      end
   end

   assign a_out = a_q;
   assign b_out = b_q;
endmodule

module tcu_drl_step_sched #(
   parameter int          N       = 2,
   parameter int          STEPS_W = 4,
   parameter int          MUL_LAT = 3,
   parameter int          TAG_W   = 8,
   // Per-format enable (bit index = format ID); a defined format whose bit is
   // cleared here is rejected like an undefined one.
   parameter logic [15:0] FMT_EN  = 16'hFFFF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [3:0]         req_fmt,
   input  logic [STEPS_W-1:0] req_steps,
   input  logic [31:0]        req_c,
   input  logic [TAG_W-1:0]   req_tag,
   input  logic               opd_valid,
   output logic               opd_ready,
   input  logic [N*32-1:0]    opd_a,
   input  logic [N*32-1:0]    opd_b,
   output logic               dp_valid,
   output logic [3:0]         dp_fmt,
   output logic [N*32-1:0]    dp_a_row,
   output logic [N*32-1:0]    dp_b_col,
   output logic [31:0]        dp_c_val,
   output logic               dp_first,
   output logic               dp_last,
   input  logic               dp_res_valid,
   input  logic [31:0]        dp_res,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [31:0]        rsp_data,
   output logic [TAG_W-1:0]   rsp_tag,
   output logic               rsp_err,
   output logic               busy
);
   // TCU format IDs
   localparam int TCU_FP32_ID = 0;
   localparam int TCU_FP16_ID = 1;
   localparam int TCU_BF16_ID = 2;
   localparam int TCU_FP8_ID  = 3;
   localparam int TCU_BF8_ID  = 4;
   localparam int TCU_I32_ID  = 8;
   localparam int TCU_I8_ID   = 9;
   localparam int TCU_U8_ID   = 10;
   localparam int TCU_I4_ID   = 11;
   localparam int TCU_U4_ID   = 12;

   localparam logic [15:0] FMT_DEFINED =
      (16'd1 << TCU_FP32_ID) | (16'd1 << TCU_FP16_ID) | (16'd1 << TCU_BF16_ID) |
      (16'd1 << TCU_FP8_ID)  | (16'd1 << TCU_BF8_ID)  | (16'd1 << TCU_I32_ID)  |
      (16'd1 << TCU_I8_ID)   | (16'd1 << TCU_U8_ID)   | (16'd1 << TCU_I4_ID)   |
      (16'd1 << TCU_U4_ID);
   localparam logic [15:0] FMT_OK_MASK = FMT_DEFINED & FMT_EN;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam int                TMR_W       = $clog2(MUL_LAT + 3);
   localparam logic [TMR_W-1:0]  TMR_TIMEOUT = TMR_W'(MUL_LAT + 2);
   localparam logic [TMR_W-1:0]  TMR_MAX     = '1;

   logic [1:0]         state_q,    state_d;
   logic [3:0]         fmt_q,      fmt_d;
   logic [STEPS_W-1:0] steps_q,    steps_d;
   logic [STEPS_W-1:0] step_cnt_q, step_cnt_d;
   logic [31:0]        c_q,        c_d;
   logic [TAG_W-1:0]   tag_q,      tag_d;
   logic [TMR_W-1:0]   tmr_q,      tmr_d;

   logic               dp_valid_q, dp_valid_d;
   logic [3:0]         dp_fmt_q,   dp_fmt_d;
   logic [31:0]        dp_c_val_q, dp_c_val_d;
   logic               dp_first_q, dp_first_d;
   logic               dp_last_q,  dp_last_d;

   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_data_q,  rsp_data_d;
   logic [TAG_W-1:0]   rsp_tag_q,   rsp_tag_d;
   logic               rsp_err_q,   rsp_err_d;

   logic               lane_ld;
   logic               step_first;
   logic               step_last;

   assign step_first = (step_cnt_q == '0);
   assign step_last  = (step_cnt_q == (steps_q - STEPS_W'(1)));

   always_comb begin
      state_d     = state_q;
      fmt_d       = fmt_q;
      steps_d     = steps_q;
      step_cnt_d  = step_cnt_q;
      c_d         = c_q;
      tag_d       = tag_q;
      tmr_d       = tmr_q;
      // Strobes and markers are single-cycle; payload holds by default.
      dp_valid_d  = 1'b0;
      dp_first_d  = 1'b0;
      dp_last_d   = 1'b0;
      dp_fmt_d    = dp_fmt_q;
      dp_c_val_d  = dp_c_val_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      rsp_err_d   = rsp_err_q;
      lane_ld     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               fmt_d      = req_fmt;
               steps_d    = (req_steps == '0) ? STEPS_W'(1) : req_steps;
               c_d        = req_c;
               tag_d      = req_tag;
               step_cnt_d = '0;
               if (FMT_OK_MASK[req_fmt]) begin
                  state_d = S_ISSUE;
               end else begin
                  // Rejected job goes straight to a failed response, never
                  // touching the datapath.
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  rsp_err_d   = 1'b1;
                  rsp_tag_d   = req_tag;
               end
            end
         end

         S_ISSUE: begin
            if (opd_valid) begin
               dp_valid_d = 1'b1;
               dp_fmt_d   = fmt_q;
               dp_first_d = step_first;
               dp_last_d  = step_last;
               dp_c_val_d = step_first ? c_q : 32'd0;
               lane_ld    = 1'b1;
               step_cnt_d = step_cnt_q + STEPS_W'(1);
               if (step_last) begin
                  // Timer reads 0 in the cycle dp_last is on the port.
                  state_d = S_DRAIN;
                  tmr_d   = '0;
               end
            end
         end

         S_DRAIN: begin
            tmr_d = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1);
            if (dp_res_valid) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = dp_res;
               rsp_err_d   = 1'b0;
               rsp_tag_d   = tag_q;
            end else if (tmr_d == TMR_TIMEOUT) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               rsp_tag_d   = tag_q;
            end
         end

         S_RESP: begin
            // dp_res_valid is deliberately not looked at here.
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         fmt_q       <= '0;
         steps_q     <= '0;
         step_cnt_q  <= '0;
         c_q         <= '0;
         tag_q       <= '0;
         tmr_q       <= '0;
         dp_valid_q  <= 1'b0;
         dp_fmt_q    <= '0;
         dp_c_val_q  <= '0;
         dp_first_q  <= 1'b0;
         dp_last_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         fmt_q       <= fmt_d;
         steps_q     <= steps_d;
         step_cnt_q  <= step_cnt_d;
         c_q         <= c_d;
         tag_q       <= tag_d;
         tmr_q       <= tmr_d;
         dp_valid_q  <= dp_valid_d;
         dp_fmt_q    <= dp_fmt_d;
         dp_c_val_q  <= dp_c_val_d;
         dp_first_q  <= dp_first_d;
         dp_last_q   <= dp_last_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Operand words, one holding register per lane.
   for (genvar i = 0; i < N; i++) begin : g_lane
      tcu_drl_step_sched_lane u_lane (
         .clk     (clk),
         .reset_n (reset_n),
         .ld      (lane_ld),
         .a_in    (opd_a[i*32 +: 32]),
         .b_in    (opd_b[i*32 +: 32]),
         .a_out   (dp_a_row[i*32 +: 32]),
         .b_out   (dp_b_col[i*32 +: 32])
      );
   end

   assign req_ready = (state_q == S_IDLE);
   assign opd_ready = (state_q == S_ISSUE);
   assign busy      = (state_q != S_IDLE);
   assign dp_valid  = dp_valid_q;
   assign dp_fmt    = dp_fmt_q;
   assign dp_c_val  = dp_c_val_q;
   assign dp_first  = dp_first_q;
   assign dp_last   = dp_last_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_tag   = rsp_tag_q;
   assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_tcu_drl_step_sched.sv
// Directed bench for tcu_drl_step_sched with hand-computed expectations.
module tb_tcu_drl_step_sched;
   localparam int N       = 2;
   localparam int STEPS_W = 4;
   localparam int MUL_LAT = 3;
   localparam int TAG_W   = 8;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               req_valid;
   logic               req_ready;
   logic [3:0]         req_fmt;
   logic [STEPS_W-1:0] req_steps;
   logic [31:0]        req_c;
   logic [TAG_W-1:0]   req_tag;
   logic               opd_valid;
   logic               opd_ready;
   logic [N*32-1:0]    opd_a;
   logic [N*32-1:0]    opd_b;
   logic               dp_valid;
   logic [3:0]         dp_fmt;
   logic [N*32-1:0]    dp_a_row;
   logic [N*32-1:0]    dp_b_col;
   logic [31:0]        dp_c_val;
   logic               dp_first;
   logic               dp_last;
   logic               dp_res_valid;
   logic [31:0]        dp_res;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_data;
   logic [TAG_W-1:0]   rsp_tag;
   logic               rsp_err;
   logic               busy;

   int n_cmp = 0;
   int n_err = 0;

   tcu_drl_step_sched #(.N(N), .STEPS_W(STEPS_W), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
      .req_steps(req_steps), .req_c(req_c), .req_tag(req_tag),
      .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_a(opd_a), .opd_b(opd_b),
      .dp_valid(dp_valid), .dp_fmt(dp_fmt), .dp_a_row(dp_a_row), .dp_b_col(dp_b_col),
      .dp_c_val(dp_c_val), .dp_first(dp_first), .dp_last(dp_last),
      .dp_res_valid(dp_res_valid), .dp_res(dp_res),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Issue-pulse recorder: sampled on the falling edge, cumulative count.
   int              cyc = 0;
   int              np  = 0;
   logic            p_first [0:63];
   logic            p_last  [0:63];
   logic [31:0]     p_c     [0:63];
   logic [3:0]      p_fmt   [0:63];
   logic [N*32-1:0] p_a     [0:63];
   int              p_cyc   [0:63];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dp_valid && np < 64) begin
         p_first[np] = dp_first;
         p_last[np]  = dp_last;
         p_c[np]     = dp_c_val;
         p_fmt[np]   = dp_fmt;
         p_a[np]     = dp_a_row;
         p_cyc[np]   = cyc;
         np = np + 1;
      end
   end

   function automatic logic [N*32-1:0] beat_a(input int k);
      return {32'hA100_0000 + k, 32'hA000_0000 + k};
   endfunction
   function automatic logic [N*32-1:0] beat_b(input int k);
      return {32'hB100_0000 + k, 32'hB000_0000 + k};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [3:0] f, input logic [STEPS_W-1:0] s,
                            input logic [31:0] c, input logic [TAG_W-1:0] t);
      req_valid = 1'b1; req_fmt = f; req_steps = s; req_c = c; req_tag = t;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic send_beat(input int k);
      opd_valid = 1'b1; opd_a = beat_a(k); opd_b = beat_b(k);
      tick();
      opd_valid = 1'b0;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      n_cmp++; if ({busy, opd_ready, dp_valid, dp_first, dp_last, rsp_valid, rsp_err} !== 7'b0) begin
         n_err++; $display("FAIL reset_ctrl got %b exp 0", {busy, opd_ready, dp_valid, dp_first, dp_last, rsp_valid, rsp_err}); end
      n_cmp++; if ({dp_a_row, dp_b_col, dp_c_val, dp_fmt, rsp_data, rsp_tag} !== '0) begin
         n_err++; $display("FAIL reset_payload got nonzero a=%h c=%h d=%h", dp_a_row, dp_c_val, rsp_data); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_fp16_job();
      int base;
      base = np;
      drive_req(4'h1, 4'd3, 32'h3F80_0000, 8'h5A);
      for (int k = 0; k < 3; k++) send_beat(k);
      n_cmp++; if ({busy, opd_ready, req_ready} !== 3'b100) begin
         n_err++; $display("FAIL fp16_drain_ports got %b exp 100", {busy, opd_ready, req_ready}); end
      repeat (MUL_LAT) tick();
      dp_res_valid = 1'b1; dp_res = 32'h4040_0000;
      tick();
      dp_res_valid = 1'b0;
      n_cmp++; if (np - base !== 3) begin n_err++; $display("FAIL fp16_pulses got %0d exp 3", np - base); end
      n_cmp++; if ({p_first[base], p_first[base+1], p_first[base+2]} !== 3'b100) begin
         n_err++; $display("FAIL fp16_first got %b exp 100", {p_first[base], p_first[base+1], p_first[base+2]}); end
      n_cmp++; if ({p_last[base], p_last[base+1], p_last[base+2]} !== 3'b001) begin
         n_err++; $display("FAIL fp16_last got %b exp 001", {p_last[base], p_last[base+1], p_last[base+2]}); end
      n_cmp++; if ({p_c[base], p_c[base+1], p_c[base+2]} !== {32'h3F80_0000, 32'h0, 32'h0}) begin
         n_err++; $display("FAIL fp16_cval got %h %h %h exp 3f800000 0 0", p_c[base], p_c[base+1], p_c[base+2]); end
      n_cmp++; if (p_a[base+1] !== beat_a(1) || p_fmt[base+1] !== 4'h1) begin
         n_err++; $display("FAIL fp16_payload got a=%h f=%h exp a=%h f=1", p_a[base+1], p_fmt[base+1], beat_a(1)); end
      n_cmp++; if ({rsp_valid, rsp_err, rsp_data, rsp_tag} !== {1'b1, 1'b0, 32'h4040_0000, 8'h5A}) begin
         n_err++; $display("FAIL fp16_rsp got v=%b e=%b d=%h t=%h exp v=1 e=0 d=40400000 t=5a", rsp_valid, rsp_err, rsp_data, rsp_tag); end
      finish_rsp();
      n_cmp++; if ({rsp_valid, req_ready, busy} !== 3'b010) begin
         n_err++; $display("FAIL fp16_after_rsp got %b exp 010", {rsp_valid, req_ready, busy}); end
   endtask

   task automatic test_zero_steps();
      int base;
      base = np;
      drive_req(4'h2, 4'd0, 32'h1111_1111, 8'h0C);
      send_beat(7);
      repeat (MUL_LAT) tick();
      dp_res_valid = 1'b1; dp_res = 32'hABCD_0123;
      tick();
      dp_res_valid = 1'b0;
      n_cmp++; if (np - base !== 1) begin n_err++; $display("FAIL zero_pulses got %0d exp 1", np - base); end
      n_cmp++; if ({p_first[base], p_last[base], p_c[base]} !== {1'b1, 1'b1, 32'h1111_1111}) begin
         n_err++; $display("FAIL zero_marks got f=%b l=%b c=%h exp 1 1 11111111", p_first[base], p_last[base], p_c[base]); end
      n_cmp++; if ({rsp_valid, rsp_err, rsp_data, rsp_tag} !== {1'b1, 1'b0, 32'hABCD_0123, 8'h0C}) begin
         n_err++; $display("FAIL zero_rsp got v=%b e=%b d=%h t=%h exp 1 0 abcd0123 0c", rsp_valid, rsp_err, rsp_data, rsp_tag); end
      finish_rsp();
   endtask

   task automatic test_bubbles();
      int base;
      logic [3:0] pat;
      base = np;
      pat = 4'b1001;
      drive_req(4'h9, 4'd2, 32'h0000_0042, 8'hB0);
      for (int k = 0; k < 4; k++) begin
         opd_valid = pat[k]; opd_a = beat_a(10 + k); opd_b = beat_b(10 + k);
         tick();
         if (k == 1) begin
            n_cmp++; if ({dp_valid, dp_first} !== 2'b00 || dp_a_row !== beat_a(10)) begin
               n_err++; $display("FAIL bubble_hold got v=%b f=%b a=%h exp 0 0 %h", dp_valid, dp_first, dp_a_row, beat_a(10)); end
         end
      end
      opd_valid = 1'b0;
      repeat (MUL_LAT) tick();
      dp_res_valid = 1'b1; dp_res = 32'h0000_0777;
      tick();
      dp_res_valid = 1'b0;
      n_cmp++; if (np - base !== 2) begin n_err++; $display("FAIL bubble_pulses got %0d exp 2", np - base); end
      n_cmp++; if (p_cyc[base+1] - p_cyc[base] !== 3) begin
         n_err++; $display("FAIL bubble_spacing got %0d exp 3", p_cyc[base+1] - p_cyc[base]); end
      n_cmp++; if ({p_first[base], p_last[base], p_first[base+1], p_last[base+1]} !== 4'b1001) begin
         n_err++; $display("FAIL bubble_marks got %b exp 1001", {p_first[base], p_last[base], p_first[base+1], p_last[base+1]}); end
      n_cmp++; if (p_a[base+1] !== beat_a(13)) begin
         n_err++; $display("FAIL bubble_beat2 got %h exp %h", p_a[base+1], beat_a(13)); end
      n_cmp++; if ({rsp_valid, rsp_err, rsp_data, rsp_tag} !== {1'b1, 1'b0, 32'h0000_0777, 8'hB0}) begin
         n_err++; $display("FAIL bubble_rsp got v=%b e=%b d=%h t=%h exp 1 0 777 b0", rsp_valid, rsp_err, rsp_data, rsp_tag); end
      finish_rsp();
   endtask

   task automatic test_bad_fmt();
      int base;
      int k;
      base = np;
      drive_req(4'hF, 4'd3, 32'h1234_5678, 8'hEE);
      k = 0;
      while (!rsp_valid && k < 2) begin tick(); k++; end
      n_cmp++; if ({rsp_valid, rsp_err, rsp_data, rsp_tag} !== {1'b1, 1'b1, 32'h0, 8'hEE}) begin
         n_err++; $display("FAIL badfmt_rsp got v=%b e=%b d=%h t=%h exp 1 1 0 ee", rsp_valid, rsp_err, rsp_data, rsp_tag); end
      n_cmp++; if (np - base !== 0 || opd_ready !== 1'b0) begin
         n_err++; $display("FAIL badfmt_no_issue got pulses=%0d opd_ready=%b exp 0 0", np - base, opd_ready); end
      finish_rsp();
      n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin
         n_err++; $display("FAIL badfmt_after got %b exp 01", {rsp_valid, req_ready}); end
   endtask

   task automatic test_timeout_hold();
      drive_req(4'h8, 4'd1, 32'h0, 8'h33);
      send_beat(20);
      // Now in the dp_last cycle; timeout response lands MUL_LAT+2 cycles later.
      repeat (MUL_LAT + 1) tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL timeout_early got %b exp 0", rsp_valid); end
      tick();
      n_cmp++; if ({rsp_valid, rsp_err, rsp_data, rsp_tag} !== {1'b1, 1'b1, 32'h0, 8'h33}) begin
         n_err++; $display("FAIL timeout_rsp got v=%b e=%b d=%h t=%h exp 1 1 0 33", rsp_valid, rsp_err, rsp_data, rsp_tag); end
      for (int i = 0; i < 5; i++) begin
         // A late result while waiting on rsp_ready must not disturb the response.
         dp_res_valid = (i == 1); dp_res = 32'hDEAD_BEEF;
         tick();
         n_cmp++; if ({rsp_valid, rsp_err, rsp_data, rsp_tag, req_ready} !== {1'b1, 1'b1, 32'h0, 8'h33, 1'b0}) begin
            n_err++; $display("FAIL hold_stable_%0d got v=%b e=%b d=%h t=%h rr=%b exp 1 1 0 33 0", i, rsp_valid, rsp_err, rsp_data, rsp_tag, req_ready); end
      end
      dp_res_valid = 1'b0;
      finish_rsp();
   endtask

   task automatic test_reset_mid_issue();
      int base;
      drive_req(4'h2, 4'd4, 32'hCAFE_0001, 8'h44);
      send_beat(30);
      send_beat(31);
      opd_valid = 1'b1; opd_a = beat_a(32); opd_b = beat_b(32);
      reset_n = 1'b0;
      tick();
      opd_valid = 1'b0;
      reset_n = 1'b1;
      n_cmp++; if ({busy, req_ready, opd_ready, dp_valid, dp_first, dp_last, rsp_valid, rsp_err} !== 8'b01000000) begin
         n_err++; $display("FAIL midrst_ctrl got %b exp 01000000", {busy, req_ready, opd_ready, dp_valid, dp_first, dp_last, rsp_valid, rsp_err}); end
      n_cmp++; if ({dp_a_row, dp_b_col, dp_c_val, dp_fmt} !== '0) begin
         n_err++; $display("FAIL midrst_payload got a=%h c=%h f=%h exp 0", dp_a_row, dp_c_val, dp_fmt); end
      dp_res_valid = 1'b1; dp_res = 32'h5555_AAAA;
      tick();
      dp_res_valid = 1'b0;
      repeat (2) tick();
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin
         n_err++; $display("FAIL midrst_stale got %b exp 00", {rsp_valid, busy}); end
      base = np;
      drive_req(4'h1, 4'd1, 32'h0000_0005, 8'h77);
      send_beat(40);
      repeat (MUL_LAT) tick();
      dp_res_valid = 1'b1; dp_res = 32'h1234_5678;
      tick();
      dp_res_valid = 1'b0;
      n_cmp++; if (np - base !== 1 || p_c[base] !== 32'h5 || p_first[base] !== 1'b1) begin
         n_err++; $display("FAIL midrst_newjob_issue got n=%0d c=%h f=%b exp 1 5 1", np - base, p_c[base], p_first[base]); end
      n_cmp++; if ({rsp_valid, rsp_err, rsp_data, rsp_tag} !== {1'b1, 1'b0, 32'h1234_5678, 8'h77}) begin
         n_err++; $display("FAIL midrst_newjob_rsp got v=%b e=%b d=%h t=%h exp 1 0 12345678 77", rsp_valid, rsp_err, rsp_data, rsp_tag); end
      finish_rsp();
   endtask

   initial begin
      reset_n = 1'b0; req_valid = 1'b0; req_fmt = '0; req_steps = '0; req_c = '0; req_tag = '0;
      opd_valid = 1'b0; opd_a = '0; opd_b = '0; dp_res_valid = 1'b0; dp_res = '0; rsp_ready = 1'b0;
      #1;
      test_reset();
      test_fp16_job();
      test_zero_steps();
      test_bubbles();
      test_bad_fmt();
      test_timeout_hold();
      test_reset_mid_issue();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/tcu_drl_step_sched.md
Name: tcu_drl_step_sched

Overview:
- Sequencer in front of the DRL tensor-core dot-product datapath (shared multiplier plus accumulator).
- Accepts one dot-product job: format, K-step count, C seed value and tag.
- Pulls one operand beat per K step, issues each beat to the datapath with first/last markers, and injects C only on the first step.
- Waits a fixed pipeline latency for the final result, then returns it on a valid/ready response port with error reporting.

Parameters:
- N, 2, 32-bit operand words per row/column per step (matches datapath N)
- STEPS_W, 4, width of K-step count
- MUL_LAT, 3, cycles from dp_last issue to dp_res_valid (datapath latency)
- TAG_W, 8, request tag width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  job request valid
- req_ready  out  1  job accept
- req_fmt  in  4  TCU format ID (VX_tcu_pkg encoding)
- req_steps  in  STEPS_W  K steps; 0 treated as 1
- req_c  in  32  accumulator seed
- req_tag  in  TAG_W  job tag
- opd_valid  in  1  operand beat valid
- opd_ready  out  1  operand beat accept
- opd_a  in  N*32  A row words
- opd_b  in  N*32  B column words
- dp_valid  out  1  issue strobe to datapath
- dp_fmt  out  4  format to datapath
- dp_a_row  out  N*32  A words
- dp_b_col  out  N*32  B words
- dp_c_val  out  32  req_c on first step, else 0
- dp_first  out  1  first step (datapath selects C, not accumulator)
- dp_last  out  1  final step
- dp_res_valid  in  1  datapath result strobe
- dp_res  in  32  datapath result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  32  result
- rsp_tag  out  TAG_W  job tag
- rsp_err  out  1  unsupported format or result timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE. All outputs 0 except req_ready=1. Counters cleared. An in-flight job is aborted and its late dp_res_valid is ignored.
- States:
  - IDLE: req_ready=1. On req_valid, latch fmt, steps (0 becomes 1), c and tag; clear step_cnt.
    - Supported fmt → ISSUE.
    - Unsupported fmt (not a defined TCU_*_ID, or its enable macro is off) → RESP with rsp_data=0, rsp_err=1; no dp_valid is issued.
  - ISSUE: opd_ready=1. On each opd_valid&&opd_ready, the next cycle drives a one-cycle registered dp_valid with:
    - operands and latched fmt;
    - dp_first = (step_cnt==0);
    - dp_last = (step_cnt==steps-1);
    - dp_c_val = dp_first ? c : 0.
    - step_cnt then increments.
    - opd_valid low is a bubble: dp_valid=0, no state change.
    - After the last handshake → DRAIN; drain timer loads 0 in the cycle dp_last is driven.
  - DRAIN: opd_ready=0. The timer increments each cycle.
    - dp_res_valid → capture dp_res, rsp_err=0 → RESP. Early arrival is accepted.
    - Timer reaches MUL_LAT+2 with no result → RESP with rsp_data=0, rsp_err=1.
  - RESP: rsp_valid=1, and rsp_data/tag/err are held stable until rsp_ready. On handshake → IDLE. rsp_valid deasserts the following cycle.
- Port gating: req_ready=0 outside IDLE. dp_res_valid outside DRAIN is ignored.
- No backpressure from the datapath; dp_valid is never stalled.
- dp_* payload holds its last value when dp_valid=0. Only dp_valid, dp_first and dp_last return to 0.
- Width rules: step_cnt is STEPS_W bits; max job = 2^STEPS_W-1 steps. Drain timer is $clog2(MUL_LAT+3) bits and saturates.
- Simultaneous events: in the cycle the last beat is accepted, the FSM moves to DRAIN and further opd_valid is not accepted. A dp_res_valid in the same cycle RESP completes is ignored.
- Throughput: 1 step/cycle in ISSUE. Minimum job turnaround = steps + MUL_LAT + 3 cycles.

Test Plan:
- FP16 job: req_steps=3, req_c=0x3F800000, tag=0x5A, operands back-to-back, dp_res=0x40400000 at MUL_LAT after dp_last → exactly 3 dp_valid pulses; first/last on pulses 1/3; dp_c_val=0x3F800000 only on pulse 1; rsp_data=0x40400000, tag=0x5A, rsp_err=0.
- req_steps=0 → exactly one dp_valid pulse with dp_first=dp_last=1; response returned normally.
- Bubbles: opd_valid pattern 1,0,0,1 with steps=2 → dp_valid pulses 3 cycles apart; step_cnt unaffected by bubbles.
- Unsupported fmt 4'hF → no dp_valid; rsp_valid within 2 cycles with rsp_data=0, rsp_err=1.
- No dp_res_valid → rsp_err=1, rsp_data=0 exactly MUL_LAT+2 cycles after dp_last. Separately, hold rsp_ready=0 for 5 cycles → rsp_* stable, req_ready=0 throughout.
- reset_n low mid-ISSUE (step 2 of 4) → next cycle IDLE, all outputs 0, req_ready=1. A stale dp_res_valid afterward causes no rsp_valid; a new job completes correctly.
